// File: rtl/frogger_round_ctrl.sv
// Frogger round sequencer: owns the game FSM, lives and score, and turns collision and
// frog-position events into respawn pulses, score increments and a per-frame move enable.
module frogger_round_ctrl #(
    parameter int c_LIVES          = 3,
    parameter int c_RESPAWN_FRAMES = 60,
    parameter int c_GOAL_ROW       = 0,
    parameter int c_MAX_SCORE      = 99
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_VSync,
    input  logic       i_Game_Start,
    input  logic       i_Collided,
    input  logic [5:0] i_Frogger_Y,
    output logic [1:0] o_State,
    output logic       o_Game_Active,
    output logic       o_Move_En,
    output logic       o_Respawn,
    output logic [1:0] o_Lives,
    output logic [6:0] o_Score,
    output logic       o_Game_Over
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_PLAY      = 2'b01,
        ST_RESPAWN   = 2'b10,
        ST_GAME_OVER = 2'b11
    } state_t;

    localparam logic [1:0] c_LIVES_INIT = 2'(c_LIVES);
    localparam logic [7:0] c_RESP_INIT  = 8'(c_RESPAWN_FRAMES);
    localparam logic [5:0] c_GOAL       = 6'(c_GOAL_ROW);
    localparam logic [6:0] c_SCORE_MAX  = 7'(c_MAX_SCORE);

    function automatic logic [6:0] sat_inc(input logic [6:0] val);
        if (val >= c_SCORE_MAX) begin
            sat_inc = c_SCORE_MAX;
        end else begin
            sat_inc = val + 7'd1;
        end
    endfunction

    state_t     state_r, state_s;
    logic [1:0] lives_r, lives_s;
    logic [6:0] score_r, score_s;
    logic [7:0] cnt_r, cnt_s;
    logic       armed_r, armed_s;
    logic       start_d_r, coll_d_r, vs_d_r;
    logic       move_en_r, respawn_r, game_active_r, game_over_r;
    logic       respawn_s, scored_s, move_en_s;
    logic       start_evt_s, coll_evt_s, tick_s, at_goal_s;

    assign start_evt_s = i_Game_Start & ~start_d_r;
    assign coll_evt_s  = i_Collided & ~coll_d_r;
    assign tick_s      = vs_d_r & ~i_VSync;
    assign at_goal_s   = (i_Frogger_Y == c_GOAL);

    // Next-state, lives/score/counter updates and pulse generation.
    always_comb begin
        state_s   = state_r;
        lives_s   = lives_r;
        score_s   = score_r;
        cnt_s     = cnt_r;
        respawn_s = 1'b0;
        scored_s  = 1'b0;
        case (state_r)
            ST_IDLE, ST_GAME_OVER: begin
                if (start_evt_s) begin
                    state_s   = ST_PLAY;
                    lives_s   = c_LIVES_INIT;
                    score_s   = 7'd0;
                    respawn_s = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            ST_PLAY: begin
                if (coll_evt_s) begin
                    // A zero-lives PLAY cannot occur; treating it as fatal keeps lives from wrapping.
                    if (lives_r <= 2'd1) begin
                        state_s = ST_GAME_OVER;
                        lives_s = 2'd0;
                    end else begin
                        state_s = ST_RESPAWN;
                        lives_s = lives_r - 2'd1;
                        cnt_s   = c_RESP_INIT;
                    end
                end else if (armed_r & at_goal_s) begin
                    score_s   = sat_inc(score_r);
                    respawn_s = 1'b1;
                    scored_s  = 1'b1;
                end else begin
                    state_s = ST_PLAY;
                end
            end
            ST_RESPAWN: begin
                if (tick_s) begin
                    cnt_s = cnt_r - 8'd1;
                    if (cnt_r == 8'd1) begin
                        state_s   = ST_PLAY;
                        respawn_s = 1'b1;
                    end else begin
                        state_s = ST_RESPAWN;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Re-arm on any entry to PLAY or once the frog leaves the goal row.
        if ((state_s == ST_PLAY) && (state_r != ST_PLAY)) begin
            armed_s = 1'b1;
        end else if (!at_goal_s) begin
            armed_s = 1'b1;
        end else if (scored_s) begin
            armed_s = 1'b0;
        end else begin
            armed_s = armed_r;
        end

        move_en_s = tick_s & (state_s == ST_PLAY);
    end

    // State, edge-detect history and registered outputs.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_r       <= ST_IDLE;
            lives_r       <= c_LIVES_INIT;
            score_r       <= 7'd0;
            cnt_r         <= 8'd0;
            armed_r       <= 1'b1;
            start_d_r     <= 1'b1;
            coll_d_r      <= 1'b0;
            vs_d_r        <= 1'b1;
            move_en_r     <= 1'b0;
            respawn_r     <= 1'b0;
            game_active_r <= 1'b0;
            game_over_r   <= 1'b0;
        end else begin
            state_r       <= state_s;
            lives_r       <= lives_s;
            score_r       <= score_s;
            cnt_r         <= cnt_s;
            armed_r       <= armed_s;
            start_d_r     <= i_Game_Start;
            coll_d_r      <= i_Collided;
            vs_d_r        <= i_VSync;
            move_en_r     <= move_en_s;
            respawn_r     <= respawn_s;
            game_active_r <= (state_s == ST_PLAY);
            game_over_r   <= (state_s == ST_GAME_OVER);
        end
    end

    assign o_State       = state_r;
    assign o_Lives       = lives_r;
    assign o_Score       = score_r;
    assign o_Move_En     = move_en_r;
    assign o_Respawn     = respawn_r;
    assign o_Game_Active = game_active_r;
    assign o_Game_Over   = game_over_r;

endmodule

// File: tb/tb_frogger_round_ctrl.sv
// Self-checking bench for frogger_round_ctrl: a rule-level game model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_frogger_round_ctrl;

    localparam int LIVES    = 3;
    localparam int FRAMES   = 60;
    localparam int GOAL_ROW = 0;
    localparam int MAXS     = 99;

    localparam int M_IDLE = 0, M_PLAY = 1, M_RESP = 2, M_OVER = 3;

    logic       i_Clk = 1'b0;
    logic       i_Reset = 1'b1;
    logic       i_VSync = 1'b1;
    logic       i_Game_Start = 1'b1;
    logic       i_Collided = 1'b0;
    logic [5:0] i_Frogger_Y = 6'd10;
    logic [1:0] o_State;
    logic       o_Game_Active, o_Move_En, o_Respawn, o_Game_Over;
    logic [1:0] o_Lives;
    logic [6:0] o_Score;

    int tests = 0;
    int fails = 0;
    int resp_seen = 0;
    int move_seen = 0;

    frogger_round_ctrl #(
        .c_LIVES(LIVES), .c_RESPAWN_FRAMES(FRAMES), .c_GOAL_ROW(GOAL_ROW), .c_MAX_SCORE(MAXS)
    ) dut (
        .i_Clk(i_Clk), .i_Reset(i_Reset), .i_VSync(i_VSync), .i_Game_Start(i_Game_Start),
        .i_Collided(i_Collided), .i_Frogger_Y(i_Frogger_Y), .o_State(o_State),
        .o_Game_Active(o_Game_Active), .o_Move_En(o_Move_En), .o_Respawn(o_Respawn),
        .o_Lives(o_Lives), .o_Score(o_Score), .o_Game_Over(o_Game_Over)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Game model: whole-game rules applied once per clock on the sampled inputs.
    int m_mode, m_lives, m_score, m_cnt, m_prev;
    bit m_armed, m_start_d, m_coll_d, m_vs_d, m_move, m_resp, m_valid;
    bit se, ce, tk, at_goal, scored;

    initial begin
        m_valid = 1'b0;
        forever begin
            @(posedge i_Clk);
            if (i_Reset) begin
                m_mode = M_IDLE; m_lives = LIVES; m_score = 0; m_cnt = 0; m_armed = 1'b1;
                m_start_d = 1'b1; m_coll_d = 1'b0; m_vs_d = 1'b1;
                m_move = 1'b0; m_resp = 1'b0; m_valid = 1'b1;
            end else if (m_valid) begin
                se = i_Game_Start && !m_start_d;
                ce = i_Collided && !m_coll_d;
                tk = m_vs_d && !i_VSync;
                at_goal = (int'(i_Frogger_Y) == GOAL_ROW);
                m_prev = m_mode;
                m_resp = 1'b0;
                scored = 1'b0;
                if ((m_mode == M_IDLE || m_mode == M_OVER) && se) begin
                    m_mode = M_PLAY; m_lives = LIVES; m_score = 0; m_resp = 1'b1;
                end else if (m_mode == M_PLAY) begin
                    if (ce && m_lives == 1) begin
                        m_mode = M_OVER; m_lives = 0;
                    end else if (ce) begin
                        m_mode = M_RESP; m_lives = m_lives - 1; m_cnt = FRAMES;
                    end else if (m_armed && at_goal) begin
                        m_score = (m_score + 1 > MAXS) ? MAXS : m_score + 1;
                        m_resp = 1'b1;
                        scored = 1'b1;
                    end
                end else if (m_mode == M_RESP && tk) begin
                    if (m_cnt == 1) begin
                        m_mode = M_PLAY; m_resp = 1'b1;
                    end
                    m_cnt = m_cnt - 1;
                end
                if (m_mode == M_PLAY && m_prev != M_PLAY) m_armed = 1'b1;
                else if (!at_goal) m_armed = 1'b1;
                else if (scored) m_armed = 1'b0;
                m_move = tk && (m_mode == M_PLAY);
                m_start_d = i_Game_Start;
                m_coll_d = i_Collided;
                m_vs_d = i_VSync;
            end
        end
    end

    // Cycle compare against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge i_Clk);
            if (m_valid) begin
                chk("state", o_State, m_mode);
                chk("lives", o_Lives, m_lives);
                chk("score", o_Score, m_score);
                chk("move_en", o_Move_En, m_move);
                chk("respawn", o_Respawn, m_resp);
                chk("game_active", o_Game_Active, (m_mode == M_PLAY));
                chk("game_over", o_Game_Over, (m_mode == M_OVER));
            end
            if (o_Respawn === 1'b1) resp_seen++;
            if (o_Move_En === 1'b1) move_seen++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge i_Clk);
    endtask

    task automatic frame();
        i_VSync = 1'b0;
        step(2);
        i_VSync = 1'b1;
        step(2);
    endtask

    int r0, mv0;

    initial begin
        // Reset with the start button held: must stay idle.
        step(3);
        i_Reset = 1'b0;
        step(5);
        chk("lit_idle_held_start", o_State, 2'b00);
        chk("lit_reset_lives", o_Lives, 2'd3);
        chk("lit_reset_score", o_Score, 7'd0);
        i_Game_Start = 1'b0;
        step(2);
        i_Game_Start = 1'b1;
        step(1);
        chk("lit_start_play", o_State, 2'b01);
        chk("lit_start_respawn", o_Respawn, 1'b1);
        i_Game_Start = 1'b0;
        step(1);
        chk("lit_respawn_one_cycle", o_Respawn, 1'b0);

        mv0 = move_seen;
        frame();
        frame();
        chk("lit_move_two_frames", move_seen - mv0, 2);

        // Held collision: one decrement, then invulnerable freeze of 60 frames.
        mv0 = move_seen;
        i_Collided = 1'b1;
        step(10);
        i_Collided = 1'b0;
        chk("lit_coll_lives", o_Lives, 2'd2);
        chk("lit_coll_state", o_State, 2'b10);
        step(1);
        i_Collided = 1'b1;
        step(1);
        i_Collided = 1'b0;
        step(1);
        chk("lit_resp_invuln", o_Lives, 2'd2);
        r0 = resp_seen;
        i_Frogger_Y = 6'd0;
        for (int f = 0; f < FRAMES - 1; f++) begin
            if (f == 30) i_Frogger_Y = 6'd10;
            frame();
        end
        chk("lit_still_frozen", o_State, 2'b10);
        chk("lit_frozen_no_move", move_seen - mv0, 0);
        chk("lit_no_goal_in_resp", o_Score, 7'd0);
        frame();
        chk("lit_back_to_play", o_State, 2'b01);
        chk("lit_exit_one_respawn", resp_seen - r0, 1);
        chk("lit_entry_move", move_seen - mv0, 1);

        // Goal scoring: once per arrival.
        i_Frogger_Y = 6'd0;
        step(5);
        chk("lit_goal_once", o_Score, 7'd1);
        i_Frogger_Y = 6'd5;
        step(2);
        i_Frogger_Y = 6'd0;
        step(2);
        chk("lit_goal_again", o_Score, 7'd2);
        i_Frogger_Y = 6'd5;
        step(2);

        // Collision and goal together: collision wins.
        i_Collided = 1'b1;
        i_Frogger_Y = 6'd0;
        step(1);
        chk("lit_cg_lives", o_Lives, 2'd1);
        chk("lit_cg_score", o_Score, 7'd2);
        i_Collided = 1'b0;
        i_Frogger_Y = 6'd10;
        for (int f = 0; f < FRAMES; f++) frame();
        chk("lit_play_again", o_State, 2'b01);

        // Last life lost, then restart.
        i_Collided = 1'b1;
        step(1);
        i_Collided = 1'b0;
        chk("lit_game_over_state", o_State, 2'b11);
        chk("lit_game_over_lives", o_Lives, 2'd0);
        chk("lit_game_over_flag", o_Game_Over, 1'b1);
        step(3);
        i_Game_Start = 1'b1;
        step(1);
        i_Game_Start = 1'b0;
        chk("lit_restart_state", o_State, 2'b01);
        chk("lit_restart_lives", o_Lives, 2'd3);
        chk("lit_restart_score", o_Score, 7'd0);

        // Score saturation.
        for (int g = 0; g < 99; g++) begin
            i_Frogger_Y = 6'd5;
            step(1);
            i_Frogger_Y = 6'd0;
            step(1);
        end
        chk("lit_score_99", o_Score, 7'd99);
        for (int g = 0; g < 2; g++) begin
            i_Frogger_Y = 6'd5;
            step(1);
            i_Frogger_Y = 6'd0;
            step(1);
        end
        chk("lit_score_sat", o_Score, 7'd99);

        // Reset mid-respawn, with other inputs active.
        i_Frogger_Y = 6'd10;
        i_Collided = 1'b1;
        step(1);
        i_Collided = 1'b0;
        for (int f = 0; f < 10; f++) frame();
        chk("lit_mid_resp", o_State, 2'b10);
        i_Reset = 1'b1;
        i_Game_Start = 1'b1;
        i_Collided = 1'b1;
        i_VSync = 1'b0;
        step(1);
        chk("lit_rst_state", o_State, 2'b00);
        chk("lit_rst_lives", o_Lives, 2'd3);
        chk("lit_rst_score", o_Score, 7'd0);
        chk("lit_rst_move", o_Move_En, 1'b0);
        chk("lit_rst_respawn", o_Respawn, 1'b0);
        i_Reset = 1'b0;
        i_VSync = 1'b1;
        step(1);
        i_Game_Start = 1'b0;
        i_Collided = 1'b0;
        step(2);
        chk("lit_rst_stays_idle", o_State, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/frogger_round_ctrl.md
# frogger_round_ctrl

Round sequencer for the Frogger game. It owns the game state machine, lives and score. It turns raw collision and frog-position events into respawn commands, score increments and a per-frame movement enable for the car controllers. It sits between the collision detector and frogger position logic on one side and the score display, LED and car blocks on the other.

## Interface

Parameters:
- c_LIVES, 3: lives loaded at game start; range 1..3.
- c_RESPAWN_FRAMES, 60: frame ticks frozen after a non-fatal collision; range 1..255.
- c_GOAL_ROW, 0: frog tile row that counts as reaching the goal.
- c_MAX_SCORE, 99: score saturation value; must be ≤ 127.

Ports:
- i_Clk  in  1  pixel clock; the block's only clock.
- i_Reset  in  1  reset; synchronous, active-high.
- i_VSync  in  1  VSync from the sync counter; its falling edge is the frame tick.
- i_Game_Start  in  1  start button, level.
- i_Collided  in  1  level collision flag from the collision detector.
- i_Frogger_Y  in  6  frog tile row.
- o_State  out  2  IDLE=00, PLAY=01, RESPAWN=10, GAME_OVER=11.
- o_Game_Active  out  1  high while in PLAY.
- o_Move_En  out  1  one-cycle pulse: a frame tick occurred while in PLAY.
- o_Respawn  out  1  one-cycle pulse commanding the frog back to its start tile.
- o_Lives  out  2  remaining lives.
- o_Score  out  7  goals reached, saturating.
- o_Game_Over  out  1  high while in GAME_OVER.

## Operation

- Edge detection (internal registers):
  - start_evt = i_Game_Start & ~start_d.
  - coll_evt = i_Collided & ~coll_d.
  - tick = vs_d & ~i_VSync.
- IDLE:
  - On start_evt → PLAY.
  - Load lives = c_LIVES, score = 0.
  - Pulse o_Respawn.
- PLAY, evaluated in priority order:
  1. coll_evt with lives == 1 → GAME_OVER, lives = 0.
  2. coll_evt with lives > 1 → RESPAWN, lives − 1, respawn counter = c_RESPAWN_FRAMES.
  3. Goal:
     - Condition: goal_armed & (i_Frogger_Y == c_GOAL_ROW).
     - Action: score + 1, saturating at c_MAX_SCORE; pulse o_Respawn; clear goal_armed; stay in PLAY.
- goal_armed:
  - Set when i_Frogger_Y != c_GOAL_ROW.
  - Set on entry to PLAY.
  - Ensures one score per arrival, even if the frog position lags o_Respawn.
- RESPAWN:
  - coll_evt and goal are ignored (invulnerable).
  - Each tick decrements the counter.
  - A tick with counter == 1 → PLAY, with an o_Respawn pulse in the same update.
  - Total freeze is exactly c_RESPAWN_FRAMES ticks.
- GAME_OVER:
  - Score and lives are held.
  - On start_evt → PLAY, with the same reload and o_Respawn as leaving IDLE.
- o_Move_En is 0 outside PLAY, so cars freeze in IDLE, RESPAWN and GAME_OVER.
- Illegal o_State encoding → IDLE on the next clock.

## Timing

- All outputs are registered.
- Reset values:
  - o_State = IDLE.
  - o_Lives = c_LIVES.
  - o_Score = 0.
  - o_Game_Active, o_Move_En, o_Respawn, o_Game_Over = 0.
  - start_d = 1, so a button held through reset does not start a game.
  - coll_d = 0.
  - vs_d = 1.
  - Respawn counter = 0.
  - goal_armed = 1.
- Latency: an input edge at clock N is detected at edge N+1. State and outputs change at that edge and are visible in cycle N+1.
- o_Move_En is high for exactly one cycle per VSync falling edge while in PLAY. The cycle that leaves PLAY produces no pulse; the cycle that enters PLAY does.
- o_Respawn is high for exactly one cycle per event.
- Simultaneous events:
  - Collision and goal in the same cycle: collision wins; no score.
  - Start in PLAY or RESPAWN: ignored.
- A held i_Collided produces a single decrement; a new decrement needs a low cycle first.
- i_Reset mid-game: all state returns to reset values on that edge, regardless of any other input.

## Test plan

- Reset with i_Game_Start held high, then hold it → stays IDLE. Release and press → PLAY next cycle, o_Lives=3, o_Score=0, one o_Respawn pulse.
- In PLAY, i_Collided high for 10 cycles → o_Lives 3→2 once, o_State=RESPAWN, o_Move_En silent. After 60 VSync falls → PLAY, one o_Respawn pulse.
- Three separated collisions → o_Lives 3,2,1,0; o_State=GAME_OVER, o_Game_Over=1. A start press → PLAY, o_Lives=3, o_Score=0.
- i_Frogger_Y=0 held 5 cycles → o_Score +1 once. Move to row 5 and back to 0 → +1 again. Preload score 99 and reach goal → stays 99.
- Collision in RESPAWN → o_Lives unchanged. Collision and goal in the same cycle → lives −1, score unchanged.
- i_Reset asserted in RESPAWN with counter mid-count → next cycle IDLE, o_Lives=3, o_Score=0, all pulses 0.
